// File: rtl/lfsr_period_meter_if.sv
// Bundles the sampled LFSR word, the start request and the measurement results.
// The master drives stimulus into the meter; the slave is the meter itself.
interface lfsr_period_meter_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
);
  logic [WIDTH-1:0]     lfsr_state;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [CNT_WIDTH-1:0] period;
  logic                 overflow;
  logic                 stuck;

  modport master (
    output lfsr_state, start,
    input  busy, done, period, overflow, stuck
  );

  modport slave (
    input  lfsr_state, start,
    output busy, done, period, overflow, stuck
  );
endinterface

// File: rtl/lfsr_period_meter.sv
// Measures how many clk cycles pass before the first sampled LFSR word reappears.
// Define LFSR_STUCK_DETECT_EN to add lock-up detection (repeated non-reference word).
module lfsr_period_meter #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  lfsr_period_meter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     ref_q, ref_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 overflow_q, overflow_d;
  logic                 match;

  assign match = (bus.lfsr_state == ref_q);

`ifdef LFSR_STUCK_DETECT_EN
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             stuck_q, stuck_d;
  logic             lock_hit;

  assign lock_hit  = (bus.lfsr_state == prev_q) && !match;
  assign bus.stuck = stuck_q;
`else
  assign bus.stuck = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ref_d      = ref_q;
    count_d    = count_q;
    period_d   = period_q;
    done_d     = done_q;
    overflow_d = overflow_q;
`ifdef LFSR_STUCK_DETECT_EN
    stuck_d    = stuck_q;
    prev_d     = prev_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          ref_d      = bus.lfsr_state;
          count_d    = CNT_ONE;
          period_d   = '0;
          done_d     = 1'b0;
          overflow_d = 1'b0;
`ifdef LFSR_STUCK_DETECT_EN
          stuck_d    = 1'b0;
          prev_d     = bus.lfsr_state;
`endif
          state_d    = COUNT;
        end
      end
      COUNT: begin
`ifdef LFSR_STUCK_DETECT_EN
        prev_d = bus.lfsr_state;
`endif
        // A match is checked first so a repeat always wins over lock-up or overflow.
        if (match) begin
          period_d = count_q;
          done_d   = 1'b1;
          state_d  = DONE;
        end
`ifdef LFSR_STUCK_DETECT_EN
        else if (lock_hit) begin
          stuck_d  = 1'b1;
          period_d = '0;
          done_d   = 1'b1;
          state_d  = DONE;
        end
`endif
        else if (count_q == CNT_MAX) begin
          period_d   = CNT_MAX;
          overflow_d = 1'b1;
          done_d     = 1'b1;
          state_d    = DONE;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == COUNT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ref_q      <= '0;
      count_q    <= '0;
      period_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef LFSR_STUCK_DETECT_EN
      stuck_q    <= 1'b0;
      prev_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ref_q      <= ref_d;
      count_q    <= count_d;
      period_q   <= period_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
`ifdef LFSR_STUCK_DETECT_EN
      stuck_q    <= stuck_d;
      prev_q     <= prev_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.period   = period_q;
  assign bus.overflow = overflow_q;
endmodule
